// File: rtl/nird_code_packer.sv
// Serial-to-parallel packer for the NIRD relative-difference bit stream.
// Collects bits MSB-first into CODE_W-bit codes framed by sof_i/eof_i.
module nird_code_packer #(
  parameter int CODE_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_i,
  input  logic              bit_valid_i,
  input  logic              sof_i,
  input  logic              eof_i,
  output logic [CODE_W-1:0] code_o,
  output logic              code_valid_o,
  output logic              code_partial_o,
  output logic [CNT_W-1:0]  code_cnt_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int IDX_W = $clog2(CODE_W);
  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_COLLECT = 1'b1;
  localparam logic [IDX_W-1:0] L_LAST = IDX_W'(CODE_W - 1);
  localparam logic [IDX_W:0]   L_CW   = (IDX_W+1)'(CODE_W);

  logic [0:0]        r_state;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [CODE_W-1:0] r_shift;
  logic [CODE_W-1:0] r_code;
  logic              r_code_valid;
  logic              r_code_partial;
  logic [CNT_W-1:0]  r_code_cnt;
  logic              r_err;

  logic [CODE_W-1:0] w_shift_n;
  logic              w_full;
  logic [IDX_W:0]    w_k;
  logic [CODE_W-1:0] w_pad_code;
  logic [CNT_W-1:0]  w_cnt_inc;

  always_comb begin
    w_shift_n  = bit_valid_i ? {r_shift[CODE_W-2:0], bit_i} : r_shift;
    w_full     = bit_valid_i && (r_bit_idx == L_LAST);
    // pending bit count after accepting this cycle's bit (never CODE_W when !w_full)
    w_k        = {1'b0, r_bit_idx} + (IDX_W+1)'(bit_valid_i);
    w_pad_code = w_shift_n << (L_CW - w_k);
    w_cnt_inc  = (r_code_cnt == {CNT_W{1'b1}}) ? r_code_cnt : r_code_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_bit_idx      <= '0;
      r_shift        <= '0;
      r_code         <= '0;
      r_code_valid   <= 1'b0;
      r_code_partial <= 1'b0;
      r_code_cnt     <= '0;
      r_err          <= 1'b0;
    end else begin
      r_code_valid <= 1'b0;
      if (sof_i) begin
        // restart: a same-cycle bit becomes the first bit of the new frame
        r_state    <= S_COLLECT;
        r_err      <= 1'b0;
        r_code_cnt <= '0;
        r_shift    <= CODE_W'(bit_valid_i & bit_i);
        r_bit_idx  <= IDX_W'(bit_valid_i);
      end else if (r_state == S_IDLE) begin
        if (bit_valid_i) r_err <= 1'b1;
      end else begin
        r_shift <= w_shift_n;
        if (w_full) begin
          r_code         <= w_shift_n;
          r_code_valid   <= 1'b1;
          r_code_partial <= 1'b0;
          r_code_cnt     <= w_cnt_inc;
        end else if (eof_i && (w_k != '0)) begin
          r_code         <= w_pad_code;
          r_code_valid   <= 1'b1;
          r_code_partial <= 1'b1;
          r_code_cnt     <= w_cnt_inc;
        end
        if (eof_i) begin
          r_state   <= S_IDLE;
          r_bit_idx <= '0;
        end else if (w_full) begin
          r_bit_idx <= '0;
        end else begin
          r_bit_idx <= w_k[IDX_W-1:0];
        end
      end
    end
  end

  assign code_o         = r_code;
  assign code_valid_o   = r_code_valid;
  assign code_partial_o = r_code_partial;
  assign code_cnt_o     = r_code_cnt;
  assign busy_o         = (r_state == S_COLLECT);
  assign err_o          = r_err;

endmodule

// File: tb/tb_nird_code_packer.sv
// Scoreboard bench for nird_code_packer: a bit-level frame model pushes
// expected codes, a negedge monitor pops and compares each strobe.
module tb_nird_code_packer;
  localparam int CODE_W = 8;
  localparam int CNT_W  = 16;

  logic              clk, rst_n;
  logic              bit_i, bit_valid_i, sof_i, eof_i;
  logic [CODE_W-1:0] code_o;
  logic              code_valid_o, code_partial_o, busy_o, err_o;
  logic [CNT_W-1:0]  code_cnt_o;

  nird_code_packer #(.CODE_W(CODE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bit_i(bit_i), .bit_valid_i(bit_valid_i),
    .sof_i(sof_i), .eof_i(eof_i), .code_o(code_o), .code_valid_o(code_valid_o),
    .code_partial_o(code_partial_o), .code_cnt_o(code_cnt_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              partial;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk, n_fail, n_strobe;

  // model state
  logic              m_busy, m_err;
  logic [CNT_W-1:0]  m_cnt;
  logic [15:0]       m_val;
  int                m_n;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && code_valid_o) begin
      n_strobe++;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {24'd0, code_o}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("code",    {24'd0, code_o}, {24'd0, e.code});
        check("partial", {31'd0, code_partial_o}, {31'd0, e.partial});
        check("cnt",     {16'd0, code_cnt_o}, {16'd0, e.cnt});
      end
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  task automatic m_emit(input logic partial);
    exp_t e;
    logic [15:0] v;
    v = m_val << (CODE_W - m_n);
    m_cnt = sat_inc(m_cnt);
    e.code = v[CODE_W-1:0];
    e.partial = partial;
    e.cnt = m_cnt;
    exp_q.push_back(e);
    m_val = '0;
    m_n = 0;
  endtask

  task automatic m_push(input logic b);
    m_val = (m_val << 1) | {15'd0, b};
    m_n++;
    if (m_n == CODE_W) m_emit(1'b0);
  endtask

  // one clock cycle of stimulus, with model update and state checks
  task automatic cyc(input logic s, input logic bv, input logic b, input logic e);
    sof_i = s; bit_valid_i = bv; bit_i = b; eof_i = e;
    if (s) begin
      m_busy = 1'b1; m_err = 1'b0; m_cnt = '0; m_val = '0; m_n = 0;
      if (bv) m_push(b);
    end else if (!m_busy) begin
      if (bv) m_err = 1'b1;
    end else begin
      if (bv) m_push(b);
      if (e) begin
        if (m_n > 0) m_emit(1'b1);
        m_busy = 1'b0;
        m_n = 0; m_val = '0;
      end
    end
    @(posedge clk); #1;
    sof_i = 0; bit_valid_i = 0; bit_i = 0; eof_i = 0;
    check("busy", {31'd0, busy_o}, {31'd0, m_busy});
    check("err",  {31'd0, err_o},  {31'd0, m_err});
    check("cnt_track", {16'd0, code_cnt_o}, {16'd0, m_cnt});
  endtask

  task automatic send_byte(input logic [7:0] v, input logic eof_last);
    for (int i = 7; i >= 0; i--) cyc(1'b0, 1'b1, v[i], (i == 0) && eof_last);
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int s0;
    n_chk = 0; n_fail = 0; n_strobe = 0;
    m_busy = 0; m_err = 0; m_cnt = '0; m_val = '0; m_n = 0;
    sof_i = 0; bit_valid_i = 0; bit_i = 0; eof_i = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_code",    {24'd0, code_o}, 0);
    check("rst_valid",   {31'd0, code_valid_o}, 0);
    check("rst_partial", {31'd0, code_partial_o}, 0);
    check("rst_cnt",     {16'd0, code_cnt_o}, 0);
    check("rst_busy",    {31'd0, busy_o}, 0);
    check("rst_err",     {31'd0, err_o}, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // full code 0xB2
    cyc(1, 0, 0, 0);
    send_byte(8'hB2, 1'b0);
    cyc(0, 0, 0, 0);
    check("hold_code", {24'd0, code_o}, 32'hB2);
    cyc(0, 0, 0, 1);          // eof with nothing pending
    drain();
    check("cnt_hold_idle", {16'd0, code_cnt_o}, 1);

    // partial code 1,1,1 -> 0xE0
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 1);
    drain();

    // exact multiple (16 bits) with random gaps
    s0 = n_strobe;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      int g;
      g = $urandom_range(0, 2);
      for (int j = 0; j < g; j++) cyc(0, 0, 0, 0);
      cyc(0, 1, 1'($urandom_range(0, 1)), i == 15);
    end
    drain();
    check("two_strobes", n_strobe - s0, 2);

    // restart mid-frame, then 0xFF with eof on last bit
    s0 = n_strobe;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1'(i & 1), 0);
    cyc(1, 0, 0, 0);
    send_byte(8'hFF, 1'b1);
    drain();
    check("restart_one_strobe", n_strobe - s0, 1);

    // sof with first bit in the same cycle, plus sof+eof collision
    cyc(1, 1, 1, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 1);          // sof wins: restart, eof ignored, bit kept
    for (int i = 0; i < 7; i++) cyc(0, 1, 1'(i == 3), 0);
    cyc(0, 1, 1, 0);          // partial pending 1 bit
    cyc(0, 0, 0, 1);
    drain();

    // error flag: bit in IDLE, then cleared by sof
    s0 = n_strobe;
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 0);
    drain();
    check("err_no_code", n_strobe - s0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);

    // asynchronous reset mid-frame after 4 bits
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0);
    rst_n = 0;
    #2;
    check("arst_busy", {31'd0, busy_o}, 0);
    check("arst_cnt",  {16'd0, code_cnt_o}, 0);
    check("arst_code", {24'd0, code_o}, 0);
    check("arst_part", {31'd0, code_partial_o}, 0);
    m_busy = 0; m_err = 0; m_cnt = '0; m_val = '0; m_n = 0;
    @(posedge clk); @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0);
    send_byte(8'h5A, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
